// File: rtl/uart_rx_8n1_if.sv
// Bundle of the serial input, enable and received-byte outputs of the 8N1 UART receiver.
// The receiver takes the slave side; the driving environment takes the master side.
interface uart_rx_8n1_if;
    logic       ena;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    modport master (
        output ena,
        output rx,
        input  data_out,
        input  data_valid,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  ena,
        input  rx,
        output data_out,
        output data_valid,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling from an 8-bit cycle counter,
// one-cycle data_valid / frame_err strobes, and a BREAK state that absorbs a held-low line.
module uart_rx_8n1 #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    uart_rx_8n1_if.slave bus
);

    localparam logic [7:0] HALF_CNT = 8'((CLKS_PER_BIT - 1) / 2);
    localparam logic [7:0] FULL_CNT = 8'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic       rx_meta_q, rx_s_q;
    logic [7:0] bit_cnt_q;
    logic [2:0] bit_idx_q;
    logic [7:0] shift_q;
    logic [7:0] data_out_q;
    logic       data_valid_q;
    logic       frame_err_q;

    logic       sample_bit;
    logic       stop_ok;
    logic       stop_bad;
    logic       state_change;

    // Synchronizer ignores ena so rx_s is always current when the receiver is re-enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.ena) begin
            case (state_q)
                S_IDLE:  if (!rx_s_q) state_d = S_START;
                S_START: if (bit_cnt_q == HALF_CNT) state_d = rx_s_q ? S_IDLE : S_DATA;
                S_DATA:  if (bit_cnt_q == FULL_CNT && bit_idx_q == 3'd7) state_d = S_STOP;
                S_STOP:  if (bit_cnt_q == FULL_CNT) state_d = rx_s_q ? S_IDLE : S_BREAK;
                S_BREAK: if (rx_s_q) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        state_change = (state_d != state_q);
        sample_bit   = bus.ena && (state_q == S_DATA) && (bit_cnt_q == FULL_CNT);
        stop_ok      = bus.ena && (state_q == S_STOP) && (bit_cnt_q == FULL_CNT) && rx_s_q;
        stop_bad     = bus.ena && (state_q == S_STOP) && (bit_cnt_q == FULL_CNT) && !rx_s_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q <= 8'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
        end else if (bus.ena) begin
            // Counter restarts on every state entry and after each data sample.
            if (state_change || sample_bit) begin
                bit_cnt_q <= 8'd0;
            end else begin
                bit_cnt_q <= bit_cnt_q + 8'd1;
            end
            if (state_q == S_START) begin
                bit_idx_q <= 3'd0;
            end else if (sample_bit) begin
                bit_idx_q <= bit_idx_q + 3'd1;
            end
            if (sample_bit) begin
                shift_q[bit_idx_q] <= rx_s_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q   <= 8'h00;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            data_valid_q <= stop_ok;
            frame_err_q  <= stop_bad;
            if (stop_ok) begin
                data_out_q <= shift_q;
            end
        end
    end

    // Strobes are masked by ena so a disabled receiver never reports a transaction.
    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q & bus.ena;
    assign bus.frame_err  = frame_err_q & bus.ena;
    assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: doc/uart_rx_8n1.md
Name: uart_rx_8n1

Overview:
- Serial receiver for 8N1 UART frames: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.
- Pairs with the team's transmitter and sits on the same single clock domain.
- Bit timing comes from an internal 8-bit cycle counter, mid-bit sampled.
- Presents each received byte with a one-cycle valid pulse; flags bad stop bits with a one-cycle error pulse.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 4..255, so it fits the 8-bit bit-timing counter.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  active-high enable; when low, FSM, counters and shift register hold.
- rx  input  1  serial line, idle high, asynchronous to clk.
- data_out  output  8  last correctly received byte.
- data_valid  output  1  one-cycle pulse when data_out is updated.
- frame_err  output  1  one-cycle pulse when the stop bit samples low.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset values: data_out=0x00, data_valid=0, frame_err=0, busy=0, FSM=IDLE, counters=0, shift register=0x00, both synchronizer flops=1.
- rx passes through a 2-flop synchronizer; call the result rx_s.
- The synchronizer always runs, regardless of ena. Everything else advances only when ena=1.
- data_valid and frame_err are forced to 0 in any cycle with ena=0.
- bit_cnt is an 8-bit counter. Each state below clears it on entry and increments it once per enabled cycle.
- IDLE:
  - rx_s==0 -> START, bit_cnt=0.
- START:
  - When bit_cnt==(CLKS_PER_BIT-1)/2, sample rx_s.
  - Sample 0 -> DATA, bit_cnt=0, bit index=0.
  - Sample 1 (glitch) -> IDLE, no pulse.
- DATA:
  - When bit_cnt==CLKS_PER_BIT-1, sample rx_s into shift register bit [index], LSB first, then clear bit_cnt.
  - After index 7 is sampled -> STOP.
- STOP:
  - When bit_cnt==CLKS_PER_BIT-1, sample rx_s.
  - Sample 1: data_out<=shift register, data_valid=1 for exactly the next cycle, go to IDLE.
  - Sample 0: frame_err=1 for the next cycle, data_out unchanged, go to BREAK.
- BREAK:
  - Wait until rx_s==1, then go to IDLE.
  - This stops a held-low line from re-triggering start detection.
- Latency: data_valid rises roughly 1 + 2 + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT cycles after the rx falling edge, mid stop bit.
- The receiver is back in IDLE before the stop bit ends, so back-to-back frames with no idle gap are received without loss.
- data_valid and frame_err are never high in the same cycle.
- An rx change during a sample cycle uses the value rx_s holds that cycle. There is no majority vote.
- rst_n asserted mid-frame:
  - All state returns to reset values immediately.
  - The partial frame is discarded.
  - After release, the receiver waits in IDLE for the next falling edge.
- A 9th data bit does not exist. Any extra low bits after a bad stop bit are absorbed in BREAK.

Test Plan:
- Setup for all scenarios: CLKS_PER_BIT=16, ena=1, bit period 16 cycles, unless noted.
- Frame 0xA5 with stop=1 -> data_out=0xA5, data_valid high exactly 1 cycle, 155±2 cycles after the rx falling edge; busy low afterwards.
- Glitch: rx low for 4 cycles, then high -> FSM returns to IDLE; no data_valid, no frame_err; data_out unchanged.
- Frame 0x3C with stop=0, rx held low 40 more cycles, then high, then frame 0x81 -> frame_err pulses once, data_out stays at its prior value, no restart while rx is low; then data_out=0x81 with data_valid.
- Back-to-back frames 0x00, 0xFF, 0x55 with zero idle gap -> three data_valid pulses in order with the matching data_out values; no frame_err.
- Reset mid-frame: assert rst_n low during bit 4 of 0xC3, release, send 0x7E -> outputs 0 during reset; no pulse for 0xC3; data_out=0x7E with one data_valid.
- ena=0 for the whole of frame 0x99, then ena=1 with rx idle -> no pulses, FSM stays in IDLE. Next frame 0x42 with ena=1 -> data_out=0x42.
